// File: rtl/usbf_wb_dma_pkg.sv
// Shared definitions for the Wishbone DMA handshake controller: register word offsets and channel states.
package usbf_wb_dma_pkg;

   // Word offsets, i.e. wb_addr_i[7:2]
   localparam logic [5:0] REG_GCTRL    = 6'h00;
   localparam logic [5:0] REG_CH_EN    = 6'h01;
   localparam logic [5:0] REG_DONE     = 6'h02;
   localparam logic [5:0] REG_ERR      = 6'h03;
   localparam logic [5:0] REG_INTA_MSK = 6'h04;
   localparam logic [5:0] REG_INTB_MSK = 6'h05;
   localparam logic [5:0] REG_CNT_BASE = 6'h10;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      GAP
   } ch_state_e;

endpackage

// File: rtl/usbf_dma_ch.sv
// One DMA handshake channel: request FSM, remaining transfer count and ack timeout counter.
module usbf_dma_ch
   import usbf_wb_dma_pkg::*;
#(
   parameter int CNT_W   = 16,
   parameter int ACK_TMO = 255
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             ep_rdy,
   input  logic             ack,
   input  logic             cnt_load,
   input  logic [CNT_W-1:0] cnt_wdata,
   output logic             req,
   output logic             done_pulse,
   output logic             err_pulse,
   output logic [CNT_W-1:0] cnt
);

   localparam int               TMO_W    = $clog2(ACK_TMO);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TMO - 1);

   ch_state_e        state;
   logic [TMO_W-1:0] tmo;
   logic             active;
   logic             in_req;

   assign active = enable & ep_rdy;
   assign in_req = (state == REQ) & ~cnt_load;

   // Flags fire on the edge the FSM leaves REQ; an ack always beats a timeout
   assign done_pulse = in_req & ack & (cnt == CNT_W'(1));
   assign err_pulse  = in_req & ~ack & active & (tmo == TMO_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         req   <= 1'b0;
         tmo   <= '0;
         cnt   <= '0;
      end else if (cnt_load) begin
         state <= IDLE;
         req   <= 1'b0;
         tmo   <= '0;
         cnt   <= cnt_wdata;
      end else begin
         case (state)
            IDLE: begin
               if (active && cnt != '0) begin
                  state <= REQ;
                  req   <= 1'b1;
                  tmo   <= '0;
               end
            end
            REQ: begin
               if (ack) begin
                  cnt   <= cnt - CNT_W'(1);
                  tmo   <= '0;
                  req   <= 1'b0;
                  state <= (cnt == CNT_W'(1)) ? IDLE : GAP;
               end else if (!active || tmo == TMO_LAST) begin
                  tmo   <= '0;
                  req   <= 1'b0;
                  state <= IDLE;
               end else begin
                  tmo <= tmo + 1'b1;
               end
            end
            GAP:     state <= IDLE;
            default: begin
               state <= IDLE;
               req   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/usbf_wb_dma_hs.sv
// Wishbone-programmable multi-channel DMA req/ack handshake controller with done/timeout interrupts.
module usbf_wb_dma_hs
   import usbf_wb_dma_pkg::*;
#(
   parameter int NUM_CH  = 16,
   parameter int ADDR_W  = 18,
   parameter int CNT_W   = 16,
   parameter int ACK_TMO = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] wb_addr_i,
   input  logic [31:0]       wb_data_i,
   output logic [31:0]       wb_data_o,
   output logic              wb_ack_o,
   input  logic              wb_we_i,
   input  logic              wb_stb_i,
   input  logic              wb_cyc_i,
   output logic              inta_o,
   output logic              intb_o,
   input  logic [NUM_CH-1:0] ep_rdy_i,
   output logic [NUM_CH-1:0] dma_req_o,
   input  logic [NUM_CH-1:0] dma_ack_i
);

   logic [5:0]        word;
   logic              acc, wr;
   logic              gctrl;
   logic [NUM_CH-1:0] ch_en, done, err, inta_msk, intb_msk;
   logic [NUM_CH-1:0] done_p, err_p, cnt_load, w1c_done, w1c_err;
   logic [CNT_W-1:0]  cnt [NUM_CH];
   logic [31:0]       rdata;
   logic              unused_bits;

   assign word        = wb_addr_i[7:2];
   assign acc         = wb_stb_i & wb_cyc_i & ~wb_ack_o;
   assign wr          = acc & wb_we_i;
   assign w1c_done    = (wr && word == REG_DONE) ? wb_data_i[NUM_CH-1:0] : '0;
   assign w1c_err     = (wr && word == REG_ERR)  ? wb_data_i[NUM_CH-1:0] : '0;
   assign unused_bits = ^{wb_addr_i, wb_data_i};

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      assign cnt_load[c] = wr && (word == REG_CNT_BASE + 6'(c));

      usbf_dma_ch #(
         .CNT_W   (CNT_W),
         .ACK_TMO (ACK_TMO)
      ) u_ch (
         .clk        (clk),
         .reset      (reset),
         .enable     (gctrl & ch_en[c]),
         .ep_rdy     (ep_rdy_i[c]),
         .ack        (dma_ack_i[c]),
         .cnt_load   (cnt_load[c]),
         .cnt_wdata  (wb_data_i[CNT_W-1:0]),
         .req        (dma_req_o[c]),
         .done_pulse (done_p[c]),
         .err_pulse  (err_p[c]),
         .cnt        (cnt[c])
      );
   end

   always_comb begin
      rdata = '0;
      case (word)
         REG_GCTRL:    rdata = 32'(gctrl);
         REG_CH_EN:    rdata = 32'(ch_en);
         REG_DONE:     rdata = 32'(done);
         REG_ERR:      rdata = 32'(err);
         REG_INTA_MSK: rdata = 32'(inta_msk);
         REG_INTB_MSK: rdata = 32'(intb_msk);
         default: begin
            for (int c = 0; c < NUM_CH; c++) begin
               if (word == REG_CNT_BASE + 6'(c)) rdata = 32'(cnt[c]);
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wb_ack_o  <= 1'b0;
         wb_data_o <= '0;
         gctrl     <= 1'b0;
         ch_en     <= '0;
         done      <= '0;
         err       <= '0;
         inta_msk  <= '0;
         intb_msk  <= '0;
         inta_o    <= 1'b0;
         intb_o    <= 1'b0;
      end else begin
         wb_ack_o  <= acc;
         wb_data_o <= acc ? rdata : '0;
         if (wr && word == REG_GCTRL)    gctrl    <= wb_data_i[0];
         if (wr && word == REG_INTA_MSK) inta_msk <= wb_data_i[NUM_CH-1:0];
         if (wr && word == REG_INTB_MSK) intb_msk <= wb_data_i[NUM_CH-1:0];
         // A timed-out channel stays disabled even if software writes CH_EN on the same edge
         if (wr && word == REG_CH_EN) ch_en <= wb_data_i[NUM_CH-1:0] & ~err_p;
         else                         ch_en <= ch_en & ~err_p;
         done   <= (done & ~w1c_done) | done_p;
         err    <= (err & ~w1c_err) | err_p;
         inta_o <= |((done | err) & inta_msk);
         intb_o <= |((done | err) & intb_msk);
      end
   end

endmodule
